// File: rtl/y86_pkg.sv
// Shared Y86-64 pipeline constants: icodes, status codes, register IDs, bubble values.
package y86_pkg;

    localparam int         WORD  = 64;
    localparam logic [3:0] RNONE = 4'hF;

    // Instruction codes
    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    // Two-bit status encoding
    localparam logic [1:0] S_AOK = 2'd0;
    localparam logic [1:0] S_HLT = 2'd1;
    localparam logic [1:0] S_ADR = 2'd2;
    localparam logic [1:0] S_INS = 2'd3;

    // Bubble value loaded into pipeline registers
    localparam logic [1:0] BUB_STAT  = S_AOK;
    localparam logic [3:0] BUB_ICODE = I_NOP;
    localparam logic [3:0] BUB_DST   = RNONE;

    // Data-memory address source
    typedef enum logic [1:0] {
        ASEL_NONE = 2'd0,
        ASEL_VALE = 2'd1,
        ASEL_VALA = 2'd2
    } addr_sel_e;

endpackage

// File: rtl/mem_ctrl_decode.sv
// Combinational icode decoder for data-memory read/write enables and address source.
module mem_ctrl_decode
    import y86_pkg::*;
(
    input  logic [3:0] icode,
    output logic       ren,
    output logic       wen,
    output addr_sel_e  asel
);

    // Loads and stores never overlap; everything else leaves memory idle
    always_comb begin
        ren  = 1'b0;
        wen  = 1'b0;
        asel = ASEL_NONE;
        case (icode)
            I_RMMOVQ, I_PUSHQ, I_CALL: begin
                wen  = 1'b1;
                asel = ASEL_VALE;
            end
            I_MRMOVQ: begin
                ren  = 1'b1;
                asel = ASEL_VALE;
            end
            I_POPQ, I_RET: begin
                ren  = 1'b1;
                asel = ASEL_VALA;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_stage_ctrl.sv
// Y86-64 memory stage: E->M register, data-memory control, status merge,
// M->W register and the sticky exception lock.
module mem_stage_ctrl #(
    parameter int         WORD  = 64,
    parameter logic [3:0] RNONE = 4'hF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [1:0]      E_stat,
    input  logic [3:0]      E_icode,
    input  logic            e_Cnd,
    input  logic [WORD-1:0] e_valE,
    input  logic [WORD-1:0] E_valA,
    input  logic [3:0]      e_dstE,
    input  logic [3:0]      E_dstM,
    input  logic            M_bubble,
    input  logic            W_stall,
    output logic [WORD-1:0] mem_addr,
    output logic            mem_wEn,
    output logic            mem_rEn,
    output logic [WORD-1:0] mem_wdata,
    input  logic [WORD-1:0] m_valM,
    input  logic            dmem_err,
    output logic [1:0]      m_stat,
    output logic [3:0]      M_icode,
    output logic            M_Cnd,
    output logic [WORD-1:0] M_valE,
    output logic [3:0]      M_dstE,
    output logic [3:0]      M_dstM,
    output logic [1:0]      W_stat,
    output logic [3:0]      W_icode,
    output logic [WORD-1:0] W_valE,
    output logic [WORD-1:0] W_valM,
    output logic [3:0]      W_dstE,
    output logic [3:0]      W_dstM,
    output logic            exc_lock
);
    import y86_pkg::*;

    logic [1:0]      m_stat_q,  m_stat_d;
    logic [3:0]      m_icode_q, m_icode_d;
    logic            m_cnd_q,   m_cnd_d;
    logic [WORD-1:0] m_vale_q,  m_vale_d;
    logic [WORD-1:0] m_vala_q,  m_vala_d;
    logic [3:0]      m_dste_q,  m_dste_d;
    logic [3:0]      m_dstm_q,  m_dstm_d;

    logic [1:0]      w_stat_q,  w_stat_d;
    logic [3:0]      w_icode_q, w_icode_d;
    logic [WORD-1:0] w_vale_q,  w_vale_d;
    logic [WORD-1:0] w_valm_q,  w_valm_d;
    logic [3:0]      w_dste_q,  w_dste_d;
    logic [3:0]      w_dstm_q,  w_dstm_d;

    logic            lock_q, lock_d;

    logic            dec_ren, dec_wen;
    addr_sel_e       dec_asel;

    mem_ctrl_decode u_dec (
        .icode (m_icode_q),
        .ren   (dec_ren),
        .wen   (dec_wen),
        .asel  (dec_asel)
    );

    // Memory interface and status merge; idle cycles ignore dmem_err and drive address 0
    always_comb begin
        mem_rEn   = dec_ren;
        mem_wEn   = dec_wen & ~lock_q;
        mem_wdata = m_vala_q;
        case (dec_asel)
            ASEL_VALE: mem_addr = m_vale_q;
            ASEL_VALA: mem_addr = m_vala_q;
            default:   mem_addr = '0;
        endcase
        m_stat = ((mem_rEn | mem_wEn) & dmem_err) ? S_ADR : m_stat_q;
    end

    // Lock sets when a non-AOK instruction advances to W; it also bubbles M on that
    // same edge so the instruction right behind the fault never enters M
    always_comb begin
        lock_d = lock_q | ((m_stat != S_AOK) & ~W_stall);

        m_stat_d  = E_stat;
        m_icode_d = E_icode;
        m_cnd_d   = e_Cnd;
        m_vale_d  = e_valE;
        m_vala_d  = E_valA;
        m_dste_d  = e_dstE;
        m_dstm_d  = E_dstM;
        if (M_bubble || lock_d) begin
            m_stat_d  = BUB_STAT;
            m_icode_d = BUB_ICODE;
            m_cnd_d   = 1'b0;
            m_vale_d  = '0;
            m_vala_d  = '0;
            m_dste_d  = RNONE;
            m_dstm_d  = RNONE;
        end

        w_stat_d  = w_stat_q;
        w_icode_d = w_icode_q;
        w_vale_d  = w_vale_q;
        w_valm_d  = w_valm_q;
        w_dste_d  = w_dste_q;
        w_dstm_d  = w_dstm_q;
        if (!W_stall) begin
            w_stat_d  = m_stat;
            w_icode_d = m_icode_q;
            w_vale_d  = m_vale_q;
            w_valm_d  = mem_rEn ? m_valM : '0;
            w_dste_d  = m_dste_q;
            w_dstm_d  = m_dstm_q;
        end
    end

    // Pipeline registers and lock; reset loads bubbles everywhere
    always_ff @(posedge clk) begin
        if (reset) begin
            m_stat_q  <= BUB_STAT;
            m_icode_q <= BUB_ICODE;
            m_cnd_q   <= 1'b0;
            m_vale_q  <= '0;
            m_vala_q  <= '0;
            m_dste_q  <= RNONE;
            m_dstm_q  <= RNONE;
            w_stat_q  <= BUB_STAT;
            w_icode_q <= BUB_ICODE;
            w_vale_q  <= '0;
            w_valm_q  <= '0;
            w_dste_q  <= RNONE;
            w_dstm_q  <= RNONE;
            lock_q    <= 1'b0;
        end else begin
            m_stat_q  <= m_stat_d;
            m_icode_q <= m_icode_d;
            m_cnd_q   <= m_cnd_d;
            m_vale_q  <= m_vale_d;
            m_vala_q  <= m_vala_d;
            m_dste_q  <= m_dste_d;
            m_dstm_q  <= m_dstm_d;
            w_stat_q  <= w_stat_d;
            w_icode_q <= w_icode_d;
            w_vale_q  <= w_vale_d;
            w_valm_q  <= w_valm_d;
            w_dste_q  <= w_dste_d;
            w_dstm_q  <= w_dstm_d;
            lock_q    <= lock_d;
        end
    end

    assign M_icode  = m_icode_q;
    assign M_Cnd    = m_cnd_q;
    assign M_valE   = m_vale_q;
    assign M_dstE   = m_dste_q;
    assign M_dstM   = m_dstm_q;
    assign W_stat   = w_stat_q;
    assign W_icode  = w_icode_q;
    assign W_valE   = w_vale_q;
    assign W_valM   = w_valm_q;
    assign W_dstE   = w_dste_q;
    assign W_dstM   = w_dstm_q;
    assign exc_lock = lock_q;

endmodule
